minmax_scan_ctrl: RTL

- Sequencer that streams a frame of N 4-bit samples through one shared Bit4_MC magnitude comparator, which has EQ, GT and LT outputs.
- Tracks the running maximum and minimum of the frame, and the index of each.
- Time-multiplexes the single comparator between the max-compare and the min-compare for every sample.
- Sits between a sample producer (valid/ready) and a consumer that samples the results on the done pulse.

---
 rtl/minmax_pkg.sv | 15 +
 rtl/Bit4_MC.sv | 16 +
 rtl/minmax_scan_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max frame scanner.
package minmax_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        CMP_MAX = 3'd3,
        CMP_MIN = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/Bit4_MC.sv
// 4-bit unsigned magnitude comparator with one-hot EQ/GT/LT outputs.
module Bit4_MC
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              eq_c,
    output logic              gt_c,
    output logic              lt_c
);

    assign eq_c = (a == b);
    assign gt_c = (a > b);
    assign lt_c = (a < b);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Streams a frame of samples through one shared comparator, tracking the
// running max/min and the first index at which each occurs.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [IDX_W-1:0]  max_idx,
    output logic [IDX_W-1:0]  min_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    state_t            state, state_d;
    logic [IDX_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] sample_reg, sample_d;
    logic [DATA_W-1:0] max_d, min_d;
    logic [IDX_W-1:0]  max_idx_d, min_idx_d;

    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_gt, cmp_lt, cmp_eq_unused;

    // Comparator operand mux: zeros in IDLE, min in CMP_MIN, max otherwise.
    always_comb begin
        cmp_a = sample_reg;
        cmp_b = max_out;
        if (state == IDLE) begin
            cmp_a = '0;
            cmp_b = '0;
        end else if (state == CMP_MIN) begin
            cmp_b = min_out;
        end
    end

    Bit4_MC u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .eq_c (cmp_eq_unused),
        .gt_c (cmp_gt),
        .lt_c (cmp_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sample_reg <= '0;
            max_out    <= '0;
            min_out    <= '0;
            max_idx    <= '0;
            min_idx    <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sample_reg <= sample_d;
            max_out    <= max_d;
            min_out    <= min_d;
            max_idx    <= max_idx_d;
            min_idx    <= min_idx_d;
        end
    end

    // Next-state, datapath updates and handshake decode.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sample_d  = sample_reg;
        max_d     = max_out;
        min_d     = min_out;
        max_idx_d = max_idx;
        min_idx_d = min_idx;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (start && !abort) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    max_d     = in_data;
                    min_d     = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    cnt_d     = IDX_W'(1);
                    state_d   = (N_SAMPLES == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = CMP_MAX;
                end
            end
            CMP_MAX: begin
                if (cmp_gt) begin
                    max_d     = sample_reg;
                    max_idx_d = cnt;
                end
                state_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (cmp_lt) begin
                    min_d     = sample_reg;
                    min_idx_d = cnt;
                end
                if (cnt == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt + IDX_W'(1);
                    state_d = WAIT;
                end
            end
            DONE: begin
                done    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything: drop this cycle's updates, keep partial results.
        if (abort && (state != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sample_d  = sample_reg;
            max_d     = max_out;
            min_d     = min_out;
            max_idx_d = max_idx;
            min_idx_d = min_idx;
        end
    end

endmodule
